// File: rtl/pipe_add_nbit.sv
// Segmented pipelined adder/subtractor: SEG bits per stage, NSEG = WIDTH/SEG stages, skewed operands and deskewed sum.
// Define PIPE_ADD_FLAGS_EN to add the registered ovf and zero flags aligned with sum.
module pipe_add_nbit #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADD_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int NSEG = WIDTH / SEG;

  logic adv;

  // The whole pipe advances or freezes together; only the output slot can block it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSEG; k++) begin : stg
    localparam int LO = (k + 1) * SEG;

    logic           v_in;
    logic           s_in;
    logic           c_in;
    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic [SEG-1:0] b_eff;
    logic [SEG:0]   seg_add;
    logic [LO-1:0]  sum_next;
    logic           v_q;
    logic           c_q;
    logic [LO-1:0]  sum_q;

    // Subtraction enters as a + ~b + ~cin; later stages see a plain carry.
    if (k == 0) begin : src
      assign v_in  = in_valid;
      assign s_in  = sub;
      assign c_in  = cin ^ sub;
      assign a_seg = a[SEG-1:0];
      assign b_seg = b[SEG-1:0];
    end else begin : src
      assign v_in  = stg[k-1].v_q;
      assign s_in  = stg[k-1].sk.s_q;
      assign c_in  = stg[k-1].c_q;
      assign a_seg = stg[k-1].sk.a_q[SEG-1:0];
      assign b_seg = stg[k-1].sk.b_q[SEG-1:0];
    end

    assign b_eff   = b_seg ^ {SEG{s_in}};
    assign seg_add = {1'b0, a_seg} + {1'b0, b_eff} + {{SEG{1'b0}}, c_in};

    if (k == 0) begin : cat
      assign sum_next = seg_add[SEG-1:0];
    end else begin : cat
      assign sum_next = {seg_add[SEG-1:0], stg[k-1].sum_q};
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= seg_add[SEG];
        sum_q <= sum_next;
      end
    end

    // Operand segments not yet consumed ride along with the op and its sub bit.
    if (k < NSEG - 1) begin : sk
      localparam int HW = WIDTH - LO;

      logic [HW-1:0] a_hi;
      logic [HW-1:0] b_hi;
      logic [HW-1:0] a_q;
      logic [HW-1:0] b_q;
      logic          s_q;

      if (k == 0) begin : hsrc
        assign a_hi = a[WIDTH-1:SEG];
        assign b_hi = b[WIDTH-1:SEG];
      end else begin : hsrc
        assign a_hi = stg[k-1].sk.a_q[HW+SEG-1:SEG];
        assign b_hi = stg[k-1].sk.b_q[HW+SEG-1:SEG];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= 1'b0;
        end else if (adv) begin
          a_q <= a_hi;
          b_q <= b_hi;
          s_q <= s_in;
        end
      end
    end

`ifdef PIPE_ADD_FLAGS_EN
    // Same-sign operands giving an opposite-sign result is carry-in XOR carry-out at the MSB.
    if (k == NSEG - 1) begin : flg
      logic ovf_q;
      logic zero_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= (a_seg[SEG-1] == b_eff[SEG-1]) && (seg_add[SEG-1] != a_seg[SEG-1]);
          zero_q <= (sum_next == '0);
        end
      end
    end
`endif
  end

  assign out_valid = stg[NSEG-1].v_q;
  assign sum       = stg[NSEG-1].sum_q;
  assign cout      = stg[NSEG-1].c_q;

`ifdef PIPE_ADD_FLAGS_EN
  assign ovf  = stg[NSEG-1].flg.ovf_q;
  assign zero = stg[NSEG-1].flg.zero_q;
`endif

endmodule

// File: doc/pipe_add_nbit.md
PIPE_ADD_NBIT -- requirements
Module: pipe_add_nbit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter SEG, default 8: bits added per pipeline stage; WIDTH SHALL be an integer multiple of SEG, with NSEG = WIDTH/SEG and NSEG >= 1.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand set on a, b, cin, sub is valid.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in when sub=0; borrow-in when sub=1.
REQ-010 sub  input  1  0 selects add, 1 selects subtract.
REQ-011 out_valid  output  1  sum and cout hold a completed result.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out; for subtract, the inverted borrow-out.
REQ-015 ovf, zero  output  1 each  present only when PIPE_ADD_FLAGS_EN is defined (see REQ-030).

Function
REQ-016 sub=0 SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-017 sub=1 SHALL compute a + ~b + ~cin, i.e. a - b - cin; cout=1 means no borrow.
REQ-018 Stage k (k = 0..NSEG-1) SHALL add segment k, bits [k*SEG +: SEG], using the carry registered from stage k-1; stage 0 uses the effective carry-in (cin, or ~cin when sub=1).
REQ-019 Upper operand segments SHALL be delayed through input skew registers; completed lower sum segments SHALL be delayed through output deskew registers; all WIDTH result bits SHALL emerge in the same cycle.
REQ-020 A per-stage valid bit and sub bit SHALL travel with each operand set.
REQ-021 Latency SHALL be exactly NSEG cycles: an operand accepted on edge n yields out_valid=1 after edge n+NSEG-1 when there is no stall.
REQ-022 Throughput SHALL be one result per cycle.
REQ-023 Global advance: adv = !out_valid | out_ready, and in_ready = adv.
REQ-024 When adv=0, every pipeline register, valid bit, sum and cout SHALL hold.
REQ-025 An accept occurs when in_valid & in_ready; when in_valid=0 and adv=1, a bubble (valid=0) SHALL enter stage 0.
REQ-026 While out_valid=1 and out_ready=0, sum and cout SHALL remain stable.
REQ-027 NSEG=1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-028 While reset is asserted, all valid bits, skew and deskew registers, carries, sum, cout and flags SHALL be 0, and in_ready SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operands; no result from before reset SHALL appear after it is released.

Configuration
REQ-030 When PIPE_ADD_FLAGS_EN is defined, the block SHALL provide:
  - ovf: signed two's-complement overflow of the operation, i.e. carry into the MSB XOR carry out of the MSB;
  - zero: asserted when sum == 0;
  - both flags registered and aligned with sum, and holding under stall.
REQ-031 When PIPE_ADD_FLAGS_EN is undefined, the ovf and zero ports and their logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=32, SEG=8)
REQ-032 Full-width carry: a=0xFFFFFFFF, b=0, cin=1, sub=0 -> 4 cycles later sum=0x00000000, cout=1, zero=1.
REQ-033 Subtract: a=5, b=7, cin=0, sub=1 -> sum=0xFFFFFFFE, cout=0; a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
REQ-034 Back-to-back streaming: 8 random operand sets on consecutive cycles with out_ready=1 -> 8 consecutive correct results, first one 4 cycles after the first accept.
REQ-035 Backpressure: out_ready=0 for 3 cycles while the pipe is full -> in_ready=0, output held stable, no result lost or duplicated, order preserved.
REQ-036 Reset pulse with 3 operands in flight -> out_valid stays 0 until a new accept, then first result after 4 cycles; plus a SEG=32 (NSEG=1) build giving latency 1.
